rename_map_table: RTL

Parametrised register alias table for the rename stage: a speculative map (front end) and an architectural map (retire) that is updated only from retired instructions. It resolves source and previous-dest mappings for a rename group, including intra-group dependencies. It restores the speculative map on pipeline flush and, optionally, from branch checkpoints. It sits between decode/rename (free-list allocation) and the ROB; the ROB receives `rn_old_pr` for freeing at retire.

---
 rtl/rename_pkg.sv | 13 +
 rtl/rat_src_lookup.sv | 31 +++
 rtl/rename_map_table.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared rename types: architectural/physical register counts, widths and handles.
// Also used by the free list and the ROB, so sizes live here rather than in the RAT.
package rename_pkg;

  localparam int unsigned AR_NUM = 32;
  localparam int unsigned PR_NUM = 128;
  localparam int unsigned AR_W   = $clog2(AR_NUM);
  localparam int unsigned PR_W   = $clog2(PR_NUM);

  typedef logic [AR_W-1:0] ar_t;
  typedef logic [PR_W-1:0] pr_t;

endpackage

// File: rtl/rat_src_lookup.sv
// Per-slot rename lookup: the youngest older in-group writer of the same AR supplies the
// PR, otherwise the speculative map does. A slot never bypasses from its own write.
module rat_src_lookup
  import rename_pkg::*;
#(
  parameter int unsigned NumSlots = 4
) (
  input  logic [AR_NUM-1:0][PR_W-1:0]   spec_map_i,
  input  logic [NumSlots-1:0]           wr_en_i,
  input  logic [NumSlots-1:0][AR_W-1:0] wr_ar_i,
  input  logic [NumSlots-1:0][PR_W-1:0] wr_pr_i,
  input  logic [NumSlots-1:0][AR_W-1:0] rd_ar_i,
  output logic [NumSlots-1:0][PR_W-1:0] rd_pr_o
);

  // Walk older slots in age order so the last match (youngest) overrides earlier ones.
  always_comb begin
    rd_pr_o = '0;
    for (int k = 0; k < NumSlots; k++) begin
      if (rd_ar_i[k] != '0) begin
        rd_pr_o[k] = spec_map_i[rd_ar_i[k]];
        for (int j = 0; j < NumSlots; j++) begin
          if ((j < k) && wr_en_i[j] && (wr_ar_i[j] == rd_ar_i[k])) begin
            rd_pr_o[k] = wr_pr_i[j];
          end
        end
      end
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// Register alias table: speculative map written by rename, architectural map written by
// retire. Flush copies the post-retire architectural map into the speculative map.
// Optional branch checkpoints are built when RAT_CKPT_EN is defined.
module rename_map_table
  import rename_pkg::*;
#(
  parameter int unsigned RN_WIDTH = 4,
  parameter int unsigned RT_WIDTH = 4,
  parameter int unsigned CKPT_NUM = 4,
  localparam int unsigned CkptW = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [RN_WIDTH-1:0]           rn_valid_i,
  input  logic [RN_WIDTH-1:0][AR_W-1:0] rn_src1_ar_i,
  input  logic [RN_WIDTH-1:0][AR_W-1:0] rn_src2_ar_i,
  output logic [RN_WIDTH-1:0][PR_W-1:0] rn_src1_pr_o,
  output logic [RN_WIDTH-1:0][PR_W-1:0] rn_src2_pr_o,
  input  logic [RN_WIDTH-1:0]           rn_dest_en_i,
  input  logic [RN_WIDTH-1:0][AR_W-1:0] rn_dest_ar_i,
  input  logic [RN_WIDTH-1:0][PR_W-1:0] rn_dest_pr_i,
  output logic [RN_WIDTH-1:0][PR_W-1:0] rn_old_pr_o,
  input  logic [RT_WIDTH-1:0]           rt_dest_en_i,
  input  logic [RT_WIDTH-1:0][AR_W-1:0] rt_dest_ar_i,
  input  logic [RT_WIDTH-1:0][PR_W-1:0] rt_dest_pr_i,
`ifdef RAT_CKPT_EN
  input  logic                          ckpt_take_i,
  input  logic [CkptW-1:0]              ckpt_take_id_i,
  input  logic                          ckpt_restore_i,
  input  logic [CkptW-1:0]              ckpt_restore_id_i,
`endif
  output logic [AR_NUM-1:0][PR_W-1:0]   arch_map_o
);

  logic [AR_NUM-1:0][PR_W-1:0] spec_q, spec_d, spec_wr, arch_q, arch_d;
  logic [RN_WIDTH-1:0]         rn_eff;
  logic [RN_WIDTH-1:0][PR_W-1:0] old_pr_raw;
  logic                        restore;

  // AR 0 is hardwired to PR 0, so writes to it never take effect.
  always_comb begin
    for (int k = 0; k < RN_WIDTH; k++) begin
      rn_eff[k] = rn_valid_i[k] & rn_dest_en_i[k] & (rn_dest_ar_i[k] != '0);
    end
  end

  rat_src_lookup #(.NumSlots(RN_WIDTH)) u_src1_lookup (
    .spec_map_i (spec_q),
    .wr_en_i    (rn_eff),
    .wr_ar_i    (rn_dest_ar_i),
    .wr_pr_i    (rn_dest_pr_i),
    .rd_ar_i    (rn_src1_ar_i),
    .rd_pr_o    (rn_src1_pr_o)
  );

  rat_src_lookup #(.NumSlots(RN_WIDTH)) u_src2_lookup (
    .spec_map_i (spec_q),
    .wr_en_i    (rn_eff),
    .wr_ar_i    (rn_dest_ar_i),
    .wr_pr_i    (rn_dest_pr_i),
    .rd_ar_i    (rn_src2_ar_i),
    .rd_pr_o    (rn_src2_pr_o)
  );

  rat_src_lookup #(.NumSlots(RN_WIDTH)) u_old_lookup (
    .spec_map_i (spec_q),
    .wr_en_i    (rn_eff),
    .wr_ar_i    (rn_dest_ar_i),
    .wr_pr_i    (rn_dest_pr_i),
    .rd_ar_i    (rn_dest_ar_i),
    .rd_pr_o    (old_pr_raw)
  );

  // old_pr is only meaningful for slots that actually overwrite a mapping.
  always_comb begin
    for (int k = 0; k < RN_WIDTH; k++) begin
      rn_old_pr_o[k] = rn_eff[k] ? old_pr_raw[k] : '0;
    end
  end

  // Apply group writes in slot order so the highest slot writing an AR wins.
  always_comb begin
    arch_d  = arch_q;
    spec_wr = spec_q;
    for (int j = 0; j < RT_WIDTH; j++) begin
      if (rt_dest_en_i[j] && (rt_dest_ar_i[j] != '0)) begin
        arch_d[rt_dest_ar_i[j]] = rt_dest_pr_i[j];
      end
    end
    for (int k = 0; k < RN_WIDTH; k++) begin
      if (rn_eff[k]) begin
        spec_wr[rn_dest_ar_i[k]] = rn_dest_pr_i[k];
      end
    end
  end

`ifdef RAT_CKPT_EN
  logic [CKPT_NUM-1:0][AR_NUM-1:0][PR_W-1:0] ckpt_q, ckpt_d;

  assign restore = ckpt_restore_i;

  // A take only lands in a cycle with neither flush nor restore.
  always_comb begin
    ckpt_d = ckpt_q;
    if (ckpt_take_i && !ckpt_restore_i && !flush_i) begin
      ckpt_d[ckpt_take_id_i] = spec_wr;
    end
  end

  // Checkpoint storage, identity at reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < CKPT_NUM; c++) begin
        for (int i = 0; i < AR_NUM; i++) begin
          ckpt_q[c][i] <= PR_W'(i);
        end
      end
    end else begin
      ckpt_q <= ckpt_d;
    end
  end
`else
  assign restore = 1'b0;
`endif

  // Speculative priority: flush, then checkpoint restore, then this group's writes.
  always_comb begin
    if (flush_i) begin
      spec_d = arch_d;
`ifdef RAT_CKPT_EN
    end else if (restore) begin
      spec_d = ckpt_q[ckpt_restore_id_i];
`endif
    end else begin
      spec_d = restore ? spec_q : spec_wr;
    end
  end

  // Map state, identity at reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < AR_NUM; i++) begin
        spec_q[i] <= PR_W'(i);
        arch_q[i] <= PR_W'(i);
      end
    end else begin
      spec_q <= spec_d;
      arch_q <= arch_d;
    end
  end

  assign arch_map_o = arch_q;

endmodule
